zap_prefetch_queue: RTL and testbench
=====================================

# zap_prefetch_queue

Parametrised successor to the pipeline FIFO stage between fetch and decode. Buffers fetched instruction words in an internal circular queue and presents them through a registered output stage. Clear/read decisions come from the same prioritised clear/stall controls as the existing stage. Adds occupancy count, almost-full and sticky overflow reporting, all with exact cycle semantics.

## Interface
- WDT, 32: payload width in bits.
- DEPTH, 8: queue entries; power of two, at least 2.
- AFULL_THRESH, 6: occupancy at or above which o_afull asserts; range 1..DEPTH.
- i_clk  in  1  single clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_write_inhibit  in  1  suppresses the write this cycle.
- i_clear_from_writeback  in  1  flush, priority 1 (highest).
- i_data_stall  in  1  stall, priority 2.
- i_clear_from_alu  in  1  flush, priority 3.
- i_stall_from_shifter  in  1  stall, priority 4.
- i_stall_from_issue  in  1  stall, priority 5.
- i_stall_from_decode  in  1  stall, priority 6.
- i_clear_from_decode  in  1  flush, priority 7.
- i_instr  in  WDT  write payload.
- i_valid  in  1  write request.
- o_full  out  1  count == DEPTH.
- o_afull  out  1  count >= AFULL_THRESH.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: a write was dropped because the queue was full.
- o_instr  out  WDT  output payload register.
- o_valid  out  1  o_instr holds a valid instruction.

## Operation
- clear: scan controls in priority order; the first asserted one decides. A clear input gives clear=1; a stall input gives clear=0. None asserted gives clear=0.
- rd_en = 1 only when none of the seven controls is asserted.
- push = i_valid && !i_write_inhibit && !o_full && !clear.
  - o_full is the pre-edge value, so writing while full is never accepted, even if a pop happens in the same cycle.
- Dropped write: i_valid && !i_write_inhibit && o_full && !clear sets o_overflow.
  - o_overflow clears only on reset or clear.
- pop = rd_en && (o_count != 0).
- Storage: DEPTH x WDT array, write pointer and read pointer of $clog2(DEPTH) bits, each wrapping modulo DEPTH.
  - o_count tracks occupancy: +1 on push only, -1 on pop only, unchanged on push+pop.
- Clear: pointers go to 0, o_count to 0 and o_valid to 0; o_overflow is cleared.
  - The write presented in the clear cycle is discarded.
  - o_instr holds its old value.
- Output stage, when not reset and not clear:
  - pop: o_instr <= head entry, o_valid <= 1.
  - rd_en with empty queue: o_valid <= 0, o_instr unchanged.
  - !rd_en (stall): o_instr and o_valid hold.
- No bypass: a word always passes through storage before reaching o_instr.
- Reset values: o_valid 0, o_instr 0, o_count 0, o_full 0, o_afull 0, o_overflow 0, both pointers 0. Storage contents are not reset.
- Reset has priority over clear, which has priority over push/pop.

## Timing
- Write-to-output latency is 2 cycles:
  - push sampled at edge t makes the entry poppable in cycle t+1;
  - with rd_en in that cycle, o_valid/o_instr update at edge t+1, visible after t+1.
- o_count, o_full and o_afull are registered-derived: they reflect pushes and pops up to the last edge. Combinational decode of the count register is permitted.
- Sustained throughput is one word per cycle with simultaneous push and pop at any occupancy below DEPTH.
- Clear takes effect at the edge it is sampled. In the next cycle o_valid=0, o_count=0, o_full=0.
- A stall freezes the output register and the read pointer; writes continue until full.

## Test plan
- Reset, then push A,B,C on consecutive cycles with no stalls:
  - o_valid rises 2 cycles after A's write; o_instr shows A, B, C on successive cycles;
  - o_count peaks at 1, then returns to 0.
- Hold i_stall_from_issue and push 8 words (DEPTH=8):
  - o_afull asserts when count reaches 6; o_full asserts at 8;
  - a 9th write sets o_overflow and o_count stays 8;
  - release the stall: all 8 words emerge in order, wrapping the pointers.
- Queue at count 5, o_valid=1, with i_clear_from_alu=1 and i_valid=1 in the same cycle:
  - next cycle o_count=0, o_valid=0, o_overflow=0, and the concurrent write is lost.
- i_data_stall together with i_clear_from_alu: no clear, everything holds.
- i_clear_from_writeback together with i_data_stall: clear occurs.
- Steady-state push+pop every cycle for 20 cycles starting from count 3:
  - o_count stays 3; output order matches input order across the wrap boundary.
- Assert i_reset mid-stream with count 4 and o_valid=1:
  - next cycle all outputs are at their reset values;
  - a following push reappears on o_instr 2 cycles later.

Source files
------------

// File: rtl/zap_prefetch_queue.sv
// Fetch-to-decode prefetch queue: circular buffer with a registered output
// stage, prioritised clear/stall controls, occupancy and overflow reporting.
module zap_prefetch_queue #(
    parameter int WDT          = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_write_inhibit,
    input  logic                     i_clear_from_writeback,
    input  logic                     i_data_stall,
    input  logic                     i_clear_from_alu,
    input  logic                     i_stall_from_shifter,
    input  logic                     i_stall_from_issue,
    input  logic                     i_stall_from_decode,
    input  logic                     i_clear_from_decode,
    input  logic [WDT-1:0]           i_instr,
    input  logic                     i_valid,
    output logic                     o_full,
    output logic                     o_afull,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [WDT-1:0]           o_instr,
    output logic                     o_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);

    logic [WDT-1:0] mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;

    logic clear;
    logic rd_en;
    logic wr_req;
    logic push;
    logic pop;
    logic drop;

    // First asserted control in priority order decides; stalls mask lower clears.
    always_comb begin
        clear = i_clear_from_writeback
             || (!i_data_stall
                 && (i_clear_from_alu
                     || (!i_stall_from_shifter && !i_stall_from_issue
                         && !i_stall_from_decode && i_clear_from_decode)));
        rd_en = !(i_clear_from_writeback || i_data_stall || i_clear_from_alu
               || i_stall_from_shifter || i_stall_from_issue
               || i_stall_from_decode || i_clear_from_decode);
        wr_req = i_valid && !i_write_inhibit && !clear;
        push   = wr_req && !o_full;
        drop   = wr_req && o_full;
        pop    = rd_en && (count != '0);
    end

    assign o_count = count;
    assign o_full  = (count == FULL_CNT);
    assign o_afull = (count >= AFULL_CNT);

    always_ff @(posedge i_clk) begin
        if (push && !i_reset)
            mem[wptr] <= i_instr;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
            o_instr    <= '0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                o_overflow <= 1'b1;
            // Output register only moves when reads are enabled.
            if (pop) begin
                o_instr <= mem[rptr];
                o_valid <= 1'b1;
            end else if (rd_en) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zap_prefetch_queue.sv
// Randomised + directed bench for zap_prefetch_queue against a queue-based model.
module tb_zap_prefetch_queue;

    localparam int DEPTH = 8;
    localparam int AFULL = 6;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_write_inhibit;
    logic [6:0]  ctrl;
    logic [31:0] i_instr;
    logic        i_valid;
    logic        o_full;
    logic        o_afull;
    logic [3:0]  o_count;
    logic        o_overflow;
    logic [31:0] o_instr;
    logic        o_valid;

    int tests = 0;
    int fails = 0;

    // Reference state
    logic [31:0] q[$];
    logic [31:0] m_out;
    logic        m_vld;
    logic        m_ovf;

    always #5 i_clk = ~i_clk;

    zap_prefetch_queue #(.WDT(32), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_write_inhibit        (i_write_inhibit),
        .i_clear_from_writeback (ctrl[0]),
        .i_data_stall           (ctrl[1]),
        .i_clear_from_alu       (ctrl[2]),
        .i_stall_from_shifter   (ctrl[3]),
        .i_stall_from_issue     (ctrl[4]),
        .i_stall_from_decode    (ctrl[5]),
        .i_clear_from_decode    (ctrl[6]),
        .i_instr                (i_instr),
        .i_valid                (i_valid),
        .o_full                 (o_full),
        .o_afull                (o_afull),
        .o_count                (o_count),
        .o_overflow             (o_overflow),
        .o_instr                (o_instr),
        .o_valid                (o_valid)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ctrl_is_clear(input int k);
        return (k == 0) || (k == 2) || (k == 6);
    endfunction

    task automatic model_step();
        bit clr;
        bit wr;
        bit full_pre;
        if (i_reset) begin
            q.delete();
            m_vld = 1'b0;
            m_out = '0;
            m_ovf = 1'b0;
            return;
        end
        clr = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (ctrl[k]) begin
                clr = ctrl_is_clear(k);
                break;
            end
        end
        if (clr) begin
            q.delete();
            m_vld = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        full_pre = (q.size() == DEPTH);
        wr = i_valid && !i_write_inhibit;
        if (ctrl == 7'd0) begin
            if (q.size() > 0) begin
                m_out = q.pop_front();
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
        end
        if (wr && !full_pre) q.push_back(i_instr);
        if (wr && full_pre)  m_ovf = 1'b1;
    endtask

    task automatic check_all();
        chk("count",    64'(o_count),    64'(q.size()));
        chk("full",     64'(o_full),     64'(q.size() == DEPTH));
        chk("afull",    64'(o_afull),    64'(q.size() >= AFULL));
        chk("overflow", 64'(o_overflow), 64'(m_ovf));
        chk("valid",    64'(o_valid),    64'(m_vld));
        chk("instr",    64'(o_instr),    64'(m_out));
    endtask

    task automatic drv(input logic rst, input logic [6:0] c, input logic v,
                       input logic inh, input logic [31:0] d);
        i_reset         = rst;
        ctrl            = c;
        i_valid         = v;
        i_write_inhibit = inh;
        i_instr         = d;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
        check_all();
    endtask

    localparam logic [6:0] ISSUE = 7'b0010000;
    localparam logic [6:0] ALU   = 7'b0000100;
    localparam logic [6:0] DSTL  = 7'b0000010;
    localparam logic [6:0] WB    = 7'b0000001;

    initial begin
        q.delete();
        m_out = '0;
        m_vld = 1'b0;
        m_ovf = 1'b0;

        // Reset
        drv(1, 0, 0, 0, 0);
        tick(); tick();
        chk("rst_count", 64'(o_count), 0);
        chk("rst_valid", 64'(o_valid), 0);
        chk("rst_instr", 64'(o_instr), 0);
        chk("rst_ovf",   64'(o_overflow), 0);

        // A,B,C back to back
        drv(0, 0, 1, 0, 32'hA);  tick();
        chk("abc_cnt1", 64'(o_count), 1);
        chk("abc_v0",   64'(o_valid), 0);
        drv(0, 0, 1, 0, 32'hB);  tick();
        chk("abc_A",    64'(o_instr), 32'hA);
        chk("abc_v1",   64'(o_valid), 1);
        drv(0, 0, 1, 0, 32'hC);  tick();
        chk("abc_B",    64'(o_instr), 32'hB);
        drv(0, 0, 0, 0, 0);      tick();
        chk("abc_C",    64'(o_instr), 32'hC);
        chk("abc_cnt0", 64'(o_count), 0);
        tick();

        // Fill under stall, overflow, then drain across wrap
        for (int i = 0; i < 9; i++) begin
            drv(0, ISSUE, 1, 0, 32'h100 + i);
            tick();
            if (i == 5) chk("afull_at6", 64'(o_afull), 1);
            if (i == 7) chk("full_at8",  64'(o_full), 1);
        end
        chk("ovf_set",  64'(o_overflow), 1);
        chk("cnt_8",    64'(o_count), 8);
        for (int i = 0; i < 9; i++) begin
            drv(0, 0, 0, 0, 0);
            tick();
            if (i < 8) chk("drain_order", 64'(o_instr), 64'(32'h100 + i));
        end

        // Count 5 with valid output, then alu clear with concurrent write
        for (int i = 0; i < 6; i++) begin drv(0, ISSUE, 1, 0, 32'h200 + i); tick(); end
        drv(0, 0, 0, 0, 0); tick();
        chk("pre_clr_cnt", 64'(o_count), 5);
        drv(0, ALU, 1, 0, 32'hDEAD); tick();
        chk("clr_cnt",   64'(o_count), 0);
        chk("clr_valid", 64'(o_valid), 0);
        chk("clr_ovf",   64'(o_overflow), 0);
        chk("clr_hold",  64'(o_instr), 32'h200);

        // data_stall masks alu clear; writeback beats data_stall
        for (int i = 0; i < 3; i++) begin drv(0, ISSUE, 1, 0, 32'h300 + i); tick(); end
        drv(0, DSTL | ALU, 0, 0, 0); tick();
        chk("dstl_alu_hold", 64'(o_count), 3);
        drv(0, DSTL | WB, 0, 0, 0); tick();
        chk("wb_clear", 64'(o_count), 0);

        // Steady push+pop from count 3
        for (int i = 0; i < 3; i++) begin drv(0, ISSUE, 1, 0, 32'h400 + i); tick(); end
        for (int i = 0; i < 20; i++) begin
            drv(0, 0, 1, 0, 32'h403 + i);
            tick();
            chk("steady_cnt", 64'(o_count), 3);
        end

        // Reset mid-stream at count 4 with valid output
        drv(0, ISSUE, 1, 0, 32'h500); tick();
        drv(0, 0, 0, 0, 0); tick(); tick(); tick();
        drv(0, 0, 0, 0, 0); tick();  // drains to empty
        for (int i = 0; i < 4; i++) begin drv(0, ISSUE, 1, 0, 32'h600 + i); tick(); end
        drv(0, 0, 1, 0, 32'h604); tick();
        chk("pre_rst_cnt", 64'(o_count), 4);
        chk("pre_rst_vld", 64'(o_valid), 1);
        drv(1, 0, 1, 0, 32'h999); tick();
        chk("mid_rst_cnt",   64'(o_count), 0);
        chk("mid_rst_instr", 64'(o_instr), 0);
        drv(0, 0, 1, 0, 32'h777); tick();
        drv(0, 0, 0, 0, 0); tick();
        chk("post_rst_word", 64'(o_instr), 32'h777);

        // Randomised phases with varying stall/clear pressure
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 250; i++) begin
                logic [6:0] c;
                c = '0;
                for (int k = 0; k < 7; k++)
                    if ($urandom_range(99) < ((ph % 2 == 0) ? 3 : 12)) c[k] = 1'b1;
                if (ph == 5 && $urandom_range(3) != 0) c[4] = 1'b1;
                drv(($urandom_range(199) == 0), c, ($urandom_range(9) < 7),
                    ($urandom_range(9) == 0), $urandom);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
